// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential DIV/DIVU unit.
// State encoding, handshake levels and the EX-stage divide opcodes live here.
package div_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StZero = 2'b01,
        StOn   = 2'b10,
        StEnd  = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [7:0] ExeDivOp  = 8'b0001_1010;
    localparam logic [7:0] ExeDivuOp = 8'b0001_1011;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for the sign fix-up of quotient and remainder.
module div_abs #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + 1'b1) : a_i;

endmodule

// File: rtl/div_seq.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle,
// stalls the pipeline while busy and pulses ready_o with {rem, quot}.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    div_state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    // Holds the dividend magnitude on entry; quotient bits shift in from the LSB.
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               signed_q, signed_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   iter_rem, iter_quot;
    logic [WIDTH-1:0]   rem_fix, quot_fix;
    logic [WIDTH:0]     trial;
    logic               borrow;
    logic               go;

    div_abs #(.WIDTH(WIDTH)) u_abs_op1 (
        .a_i   (opdata1_i),
        .neg_i (signed_div_i & opdata1_i[WIDTH-1]),
        .y_o   (op1_abs)
    );

    div_abs #(.WIDTH(WIDTH)) u_abs_op2 (
        .a_i   (opdata2_i),
        .neg_i (signed_div_i & opdata2_i[WIDTH-1]),
        .y_o   (op2_abs)
    );

    div_abs #(.WIDTH(WIDTH)) u_abs_quot (
        .a_i   (iter_quot),
        .neg_i (signed_q & (sign1_q ^ sign2_q)),
        .y_o   (quot_fix)
    );

    div_abs #(.WIDTH(WIDTH)) u_abs_rem (
        .a_i   (iter_rem),
        .neg_i (signed_q & sign1_q),
        .y_o   (rem_fix)
    );

    // The shifted partial remainder can need WIDTH+1 bits; a non-negative
    // difference always fits in WIDTH bits, so the MSB is a clean borrow.
    always_comb begin
        trial     = {rem_q, quot_q[WIDTH-1]} - {1'b0, divisor_q};
        borrow    = trial[WIDTH];
        iter_rem  = borrow ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : trial[WIDTH-1:0];
        iter_quot = {quot_q[WIDTH-2:0], ~borrow};
    end

    assign go = (start_i == DivStart) && !annul_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        ready_d   = DivResultNotReady;
        result_d  = '0;
        stall_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    stall_o = 1'b1;
                    if (opdata2_i == '0) begin
                        state_d = StZero;
                    end else begin
                        state_d   = StOn;
                        quot_d    = op1_abs;
                        divisor_d = op2_abs;
                        signed_d  = signed_div_i;
                        sign1_d   = opdata1_i[WIDTH-1];
                        sign2_d   = opdata2_i[WIDTH-1];
                        cnt_d     = '0;
                        rem_d     = '0;
                    end
                end
            end
            StZero: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    stall_o = 1'b1;
                    state_d = StEnd;
                    ready_d = DivResultReady;
                end
            end
            StOn: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    stall_o = 1'b1;
                    rem_d   = iter_rem;
                    quot_d  = iter_quot;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d  = StEnd;
                        ready_d  = DivResultReady;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end
            StEnd: begin
                // Result is consumed this cycle; annul here is the consumer's problem.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            ready_q   <= DivResultNotReady;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for 32-bit DIV/DIVU (restoring radix-2, one quotient bit per cycle) in the EX stage.
- Accepts operands when EX decodes EXE_DIV_OP/EXE_DIVU_OP and holds the pipeline via stall_o until the result is ready.
- Delivers {remainder, quotient} to the HI/LO write path.
- Supports annulment by exception/flush.

Parameters:
- WIDTH, 32, operand width; the quotient/remainder iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a divide; sampled only in IDLE.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- annul_i  in  1  abort the operation in progress (exception/flush).
- result_o  out  2*WIDTH  {remainder (HI), quotient (LO)}; valid only while ready_o=1.
- ready_o  out  1  result valid, one-cycle pulse.
- stall_o  out  1  pipeline hold request to the hazard unit.

Behaviour:
- Reset: state=IDLE, ready_o=0, result_o=0, counter=0. Internal dividend/divisor registers are cleared.
- States and transitions:
  - IDLE: if start_i && !annul_i && divisor==0, go to ZERO. If start_i && !annul_i && divisor!=0, go to ON. Otherwise stay in IDLE.
  - Entering ON: latch |dividend| and |divisor| when signed_div_i=1 and the operand MSB=1 (two's complement negation); otherwise latch raw values. Latch signed_div_i, the dividend sign and the divisor sign. Clear the counter and the partial remainder.
  - ZERO: one cycle; next state END with result 0 (quotient=0, remainder=0). No trap is raised.
  - ON: each cycle, shift {rem,quot} left by 1 and trial-subtract the divisor from the upper half. If non-negative, take the difference and set quot LSB=1; else keep it and set quot LSB=0. Increment the counter. After the WIDTH-th iteration (counter==WIDTH-1), go to END.
  - END: ready_o=1 for exactly this cycle and result_o is driven. Next state IDLE unconditionally.
- Sign fix-up, applied when result_o is formed in END and only when signed:
  - quotient is negated if the dividend and divisor signs differ;
  - remainder is negated if the dividend was negative.
- Latency: start sampled at edge k → ON during cycles k+1..k+WIDTH → END (ready_o=1) at cycle k+WIDTH+1. The divide-by-zero path has ready_o at k+2.
- stall_o = (state==IDLE && start_i && !annul_i) || state==ZERO || state==ON. stall_o is 0 in END so the EX instruction advances in the same cycle it consumes the result.
- ready_o and result_o are registered. result_o returns to 0 in every state except END.
- Boundary conditions:
  - annul_i=1 in ON or ZERO: the next state is IDLE, no ready_o pulse, and stall_o drops in the cycle annul_i is seen.
  - annul_i=1 in END: ready_o still pulses and the consumer discards it.
  - start_i in ON/ZERO/END: ignored; no restart or re-latch.
  - start_i held high across END: a new operation begins only in the IDLE cycle after END.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0 (wrap, no overflow flag).
  - Operand changes after sampling have no effect.
  - rst mid-operation: immediate return to IDLE on the next edge, outputs cleared.
- Width rules: counter width is clog2(WIDTH)+1. Trial subtraction is WIDTH+1 bits wide, with the borrow in the MSB.

Decomposition:
- Constants in defines.vh:
  - state encodings DIV_IDLE, DIV_ZERO, DIV_ON, DIV_END (2 bits);
  - DIV_START/DIV_STOP and DIV_RESULT_READY/NOT_READY levels, next to the existing EXE_DIV_OP/EXE_DIVU_OP alucontrol codes.
- The main decoder drives start_i and signed_div_i from alucontrol.
- One sub-module is natural: div_abs (combinational conditional two's-complement negate). It is instantiated for operand entry and for result fix-up.

Test Plan:
- DIVU 100/7 → ready_o at cycle k+33, result_o = {0x00000002, 0x0000000E}; stall_o high cycles k..k+32, low at k+33.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
- Divide by zero, 5/0 → ready_o at k+2 with result_o=0; stall_o high for cycles k and k+1 only.
- annul_i pulsed at cycle k+10 of DIVU 1000/3 → IDLE at k+11, no ready_o ever. A fresh start at k+12 completes normally with {1, 333}.
- rst asserted at k+5 mid-operation → IDLE at k+6 with ready_o=0 and result_o=0. start_i held during ON is ignored; the result matches the first operands.
